// File: rtl/wave_param_loader.sv
// Per-voice parameter loader for the eight-voice wave generator.
// Writes fill a shadow bank; a commit copies it to the live bank on the next sample tick.
module wave_param_loader (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [2:0]          wr_chan,
    input  logic [1:0]          wr_field,
    input  logic [15:0]         wr_data,
    input  logic                commit_req,
    output logic                commit_pending,
    output logic                commit_done,
    output logic                err,
    output logic signed [127:0] amps,
    output logic [127:0]        offsets,
    output logic [127:0]        phasewords
);

    typedef enum logic {
        ACCEPT = 1'b0,
        ARMED  = 1'b1
    } state_t;

    localparam logic [1:0] FIELD_AMP    = 2'd0;
    localparam logic [1:0] FIELD_OFFSET = 2'd1;
    localparam logic [1:0] FIELD_PHASE  = 2'd2;

    state_t               r_state;
    logic [7:0][15:0]     r_sh_amp;
    logic [7:0][15:0]     r_sh_off;
    logic [7:0][15:0]     r_sh_phase;
    logic signed [127:0]  r_amps;
    logic [127:0]         r_offsets;
    logic [127:0]         r_phasewords;
    logic                 r_wr_ready;
    logic                 r_commit_pending;
    logic                 r_commit_done;
    logic                 r_err;
    logic                 w_wr_fire;

    // wr_ready is high exactly in ACCEPT, so the handshake also implies ACCEPT.
    assign w_wr_fire = wr_valid & r_wr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ACCEPT;
            r_sh_amp         <= '0;
            r_sh_off         <= '0;
            r_sh_phase       <= '0;
            r_amps           <= '0;
            r_offsets        <= '0;
            r_phasewords     <= '0;
            r_wr_ready       <= 1'b1;
            r_commit_pending <= 1'b0;
            r_commit_done    <= 1'b0;
            r_err            <= 1'b0;
        end else begin
            r_commit_done <= 1'b0;
            case (r_state)
                ACCEPT: begin
                    if (w_wr_fire) begin
                        case (wr_field)
                            FIELD_AMP:    r_sh_amp[wr_chan]   <= wr_data;
                            FIELD_OFFSET: r_sh_off[wr_chan]   <= wr_data;
                            FIELD_PHASE:  r_sh_phase[wr_chan] <= wr_data;
                            default:      r_err               <= 1'b1;
                        endcase
                    end
                    // A tick in this same cycle is deliberately not used for the copy.
                    if (commit_req) begin
                        r_state          <= ARMED;
                        r_wr_ready       <= 1'b0;
                        r_commit_pending <= 1'b1;
                    end
                end
                ARMED: begin
                    if (sample_tick) begin
                        r_amps           <= r_sh_amp;
                        r_offsets        <= r_sh_off;
                        r_phasewords     <= r_sh_phase;
                        r_commit_done    <= 1'b1;
                        r_commit_pending <= 1'b0;
                        r_wr_ready       <= 1'b1;
                        r_state          <= ACCEPT;
                    end
                end
                default: begin
                    r_state          <= ACCEPT;
                    r_wr_ready       <= 1'b1;
                    r_commit_pending <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready       = r_wr_ready;
    assign commit_pending = r_commit_pending;
    assign commit_done    = r_commit_done;
    assign err            = r_err;
    assign amps           = r_amps;
    assign offsets        = r_offsets;
    assign phasewords     = r_phasewords;

endmodule

// File: tb/tb_wave_param_loader.sv
// Directed self-checking bench for wave_param_loader.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_wave_param_loader;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                sample_tick = 1'b0;
    logic                wr_valid = 1'b0;
    logic                wr_ready;
    logic [2:0]          wr_chan = '0;
    logic [1:0]          wr_field = '0;
    logic [15:0]         wr_data = '0;
    logic                commit_req = 1'b0;
    logic                commit_pending;
    logic                commit_done;
    logic                err;
    logic signed [127:0] amps;
    logic [127:0]        offsets;
    logic [127:0]        phasewords;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_amps;
    logic [127:0] exp_offsets;
    logic [127:0] exp_phase;

    wave_param_loader dut (
        .clk            (clk),
        .reset          (reset),
        .sample_tick    (sample_tick),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_chan        (wr_chan),
        .wr_field       (wr_field),
        .wr_data        (wr_data),
        .commit_req     (commit_req),
        .commit_pending (commit_pending),
        .commit_done    (commit_done),
        .err            (err),
        .amps           (amps),
        .offsets        (offsets),
        .phasewords     (phasewords)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] ch, input logic [1:0] fld, input logic [15:0] d);
        wr_valid = 1'b1;
        wr_chan  = ch;
        wr_field = fld;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample_tick = ~sample_tick;
            tick();
        end
        reset = 1'b0;
        sample_tick = 1'b0;
        checks++; if (amps !== 128'd0) begin errors++; $display("FAIL reset_amps got %h exp 0", amps); end
        checks++; if (offsets !== 128'd0) begin errors++; $display("FAIL reset_offsets got %h exp 0", offsets); end
        checks++; if (phasewords !== 128'd0) begin errors++; $display("FAIL reset_phase got %h exp 0", phasewords); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", wr_ready); end
        checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", commit_pending); end
        checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", commit_done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    endtask

    task automatic test_write_commit();
        write(3'd3, 2'd0, 16'h7FFF);
        write(3'd0, 2'd2, 16'h0100);
        write(3'd7, 2'd1, 16'h8000);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL wc_pending got %b exp 1", commit_pending); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL wc_ready_armed got %b exp 0", wr_ready); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (amps !== 128'd0 || offsets !== 128'd0 || phasewords !== 128'd0) begin
            errors++; $display("FAIL wc_pre_tick amps %h offs %h phase %h exp all 0", amps, offsets, phasewords);
        end
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        exp_amps    = 128'h7FFF << 48;
        exp_offsets = 128'h8000 << 112;
        exp_phase   = 128'h0100;
        checks++; if (amps[63:48] !== 16'h7FFF) begin errors++; $display("FAIL wc_amp3 got %h exp 7fff", amps[63:48]); end
        checks++; if (phasewords[15:0] !== 16'h0100) begin errors++; $display("FAIL wc_phase0 got %h exp 0100", phasewords[15:0]); end
        checks++; if (offsets[127:112] !== 16'h8000) begin errors++; $display("FAIL wc_off7 got %h exp 8000", offsets[127:112]); end
        checks++; if (amps !== exp_amps || offsets !== exp_offsets || phasewords !== exp_phase) begin
            errors++; $display("FAIL wc_full amps %h offs %h phase %h", amps, offsets, phasewords);
        end
        checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL wc_done got %b exp 1", commit_done); end
        checks++; if (commit_pending !== 1'b0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL wc_release pending %b ready %b exp 0 1", commit_pending, wr_ready);
        end
        tick();
        checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL wc_done_pulse got %b exp 0", commit_done); end
    endtask

    task automatic test_commit_with_tick();
        write(3'd1, 2'd0, 16'h1111);
        commit_req  = 1'b1;
        sample_tick = 1'b1;
        tick();
        commit_req  = 1'b0;
        sample_tick = 1'b0;
        checks++; if (commit_pending !== 1'b1 || commit_done !== 1'b0) begin
            errors++; $display("FAIL cwt_armed pending %b done %b exp 1 0", commit_pending, commit_done);
        end
        checks++; if (amps[31:16] !== 16'h0000) begin errors++; $display("FAIL cwt_no_copy got %h exp 0000", amps[31:16]); end
        tick();
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        exp_amps[31:16] = 16'h1111;
        checks++; if (amps !== exp_amps || commit_done !== 1'b1) begin
            errors++; $display("FAIL cwt_next_tick amps %h done %b exp %h 1", amps, commit_done, exp_amps);
        end
    endtask

    task automatic test_write_with_commit();
        wr_valid   = 1'b1;
        wr_chan    = 3'd4;
        wr_field   = 2'd2;
        wr_data    = 16'hABCD;
        commit_req = 1'b1;
        tick();
        wr_valid   = 1'b0;
        commit_req = 1'b0;
        checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL wwc_pending got %b exp 1", commit_pending); end
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        exp_phase[79:64] = 16'hABCD;
        checks++; if (phasewords !== exp_phase) begin errors++; $display("FAIL wwc_phase got %h exp %h", phasewords, exp_phase); end
    endtask

    task automatic test_backpressure();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        wr_valid = 1'b1;
        wr_chan  = 3'd2;
        wr_field = 2'd0;
        wr_data  = 16'h1234;
        tick();
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", wr_ready); end
        tick();
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        checks++; if (amps !== exp_amps || commit_done !== 1'b1) begin
            errors++; $display("FAIL bp_first_commit amps %h done %b exp %h 1", amps, commit_done, exp_amps);
        end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        checks++; if (amps[47:32] !== 16'h0000) begin errors++; $display("FAIL bp_hidden got %h exp 0000", amps[47:32]); end
        do_commit();
        exp_amps[47:32] = 16'h1234;
        checks++; if (amps !== exp_amps) begin errors++; $display("FAIL bp_second_commit got %h exp %h", amps, exp_amps); end
    endtask

    task automatic test_last_write_wins();
        write(3'd6, 2'd1, 16'h0001);
        write(3'd6, 2'd1, 16'h0002);
        do_commit();
        exp_offsets[111:96] = 16'h0002;
        checks++; if (offsets !== exp_offsets) begin errors++; $display("FAIL lww_offsets got %h exp %h", offsets, exp_offsets); end
    endtask

    task automatic test_illegal();
        write(3'd0, 2'd3, 16'hFFFF);
        checks++; if (err !== 1'b1 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL ill_err err %b ready %b exp 1 1", err, wr_ready);
        end
        do_commit();
        checks++; if (amps !== exp_amps || offsets !== exp_offsets || phasewords !== exp_phase) begin
            errors++; $display("FAIL ill_banks amps %h offs %h phase %h", amps, offsets, phasewords);
        end
        do_commit();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_sticky got %b exp 1", err); end
    endtask

    task automatic test_reset_armed();
        write(3'd5, 2'd0, 16'h0042);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL ra_pending got %b exp 1", commit_pending); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        checks++; if (amps !== 128'd0 || offsets !== 128'd0 || phasewords !== 128'd0) begin
            errors++; $display("FAIL ra_banks amps %h offs %h phase %h exp all 0", amps, offsets, phasewords);
        end
        checks++; if (commit_pending !== 1'b0 || commit_done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL ra_flags pending %b done %b err %b exp 0 0 0", commit_pending, commit_done, err);
        end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ra_ready got %b exp 1", wr_ready); end
    endtask

    initial begin
        exp_amps    = '0;
        exp_offsets = '0;
        exp_phase   = '0;
        test_reset();
        test_write_commit();
        test_commit_with_tick();
        test_write_with_commit();
        test_backpressure();
        test_last_write_wins();
        test_illegal();
        test_reset_armed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
